// File: rtl/mod10_down_counter.sv
// Cascaded multi-digit BCD countdown timer with load clamping and a one-cycle done pulse.
// Define MOD10_DOWN_RELOAD_EN for periodic mode: the terminal step reloads the last loaded value.
module mod10_down_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    input  logic                  en_i,
    output logic [4*DIGITS-1:0]   q_o,
    output logic                  busy_o,
    output logic                  zero_o,
    output logic                  done_o
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ZERO_C = {W{1'b0}};
    localparam logic [W-1:0] ONE_C  = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   reload_q, reload_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [W-1:0]   clamped_s;
    logic [W-1:0]   dec_s;

    // Saturate every non-decimal nibble to 9 so the count is always valid BCD.
    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        r = ZERO_C;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            r[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
        end
        return r;
    endfunction

    // Ripple-borrow decrement: a digit at 0 wraps to 9 and passes the borrow upward.
    function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        logic         borrow;
        r      = ZERO_C;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = d - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*i +: 4] = d;
            end
        end
        return r;
    endfunction

    assign clamped_s = clamp_bcd(load_val_i);
    assign dec_s     = dec_bcd(q_q);

    // Next-state selection: load beats counting; reset is handled in the register block.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (load_i) begin
            q_d      = clamped_s;
            reload_d = clamped_s;
            state_d  = (clamped_s != ZERO_C) ? RUN : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    if (!en_i) begin
                        state_d = RUN;
                    end else if (q_q == ONE_C) begin
                        done_d = 1'b1;
`ifdef MOD10_DOWN_RELOAD_EN
                        q_d     = reload_q;
                        state_d = RUN;
`else
                        q_d     = ZERO_C;
                        state_d = IDLE;
`endif
                    end else if (q_q == ZERO_C) begin
                        // Unreachable in normal use; park instead of wrapping to all nines.
                        state_d = IDLE;
                    end else begin
                        q_d = dec_s;
                    end
                end
                default: begin
                    state_d = IDLE;
                    q_d     = ZERO_C;
                end
            endcase
        end
        busy_d = (state_d == RUN);
    end

    // State, count, reload value and status flags, all cleared by synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            q_q      <= ZERO_C;
            reload_q <= ZERO_C;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign q_o    = q_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign zero_o = (q_q == ZERO_C);

endmodule

// File: tb/tb_mod10_down_counter.sv
// Scoreboard bench: the driver queues hand-computed expectations, a monitor checks them each cycle.
module tb_mod10_down_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b0, load = 1'b0, en = 1'b0;
    logic [7:0]  lv = 8'h00;
    logic [7:0]  q;
    logic        busy, zero, done;

    logic        load3 = 1'b0;
    logic [11:0] lv3 = 12'h000;
    logic [11:0] q3;
    logic        busy3, zero3, done3;

    logic        chk3_g = 1'b0;
    logic [11:0] eq3_g = 12'h000;

    typedef struct packed {
        logic [7:0]  q;
        logic        busy;
        logic        done;
        logic        chk3;
        logic [11:0] q3;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_n;
    int    vectors = 0;
    int    miscompares = 0;

`ifdef MOD10_DOWN_RELOAD_EN
    logic [7:0] per_q[10] = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03, 8'h02};
    logic       per_b[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       per_d[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    logic [7:0] per_q[10] = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       per_b[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       per_d[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    mod10_down_counter #(.DIGITS(2)) dut (
        .clk_i(clk), .reset_i(reset), .load_i(load), .load_val_i(lv), .en_i(en),
        .q_o(q), .busy_o(busy), .zero_o(zero), .done_o(done)
    );

    mod10_down_counter #(.DIGITS(3)) dut3 (
        .clk_i(clk), .reset_i(reset), .load_i(load3), .load_val_i(lv3), .en_i(en),
        .q_o(q3), .busy_o(busy3), .zero_o(zero3), .done_o(done3)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd2(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic step(input string nm, input logic r, input logic ld, input logic [7:0] v,
                        input logic e, input logic [7:0] eq, input logic eb, input logic ed);
        exp_t x;
        reset = r; load = ld; lv = v; en = e;
        x.q = eq; x.busy = eb; x.done = ed; x.chk3 = chk3_g; x.q3 = eq3_g;
        sb_q.push_back(x);
        name_q.push_back(nm);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic park();
        step("park", 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Monitor: one expectation per clock, sampled shortly after the active edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            mon_n = name_q.pop_front();
            vectors++;
            if (q !== mon_e.q || busy !== mon_e.busy || done !== mon_e.done ||
                zero !== (mon_e.q == 8'h00) || (mon_e.chk3 && q3 !== mon_e.q3)) begin
                miscompares++;
                $display("FAIL %s: got q=%h busy=%b done=%b zero=%b q3=%h, want q=%h busy=%b done=%b zero=%b q3=%h",
                         mon_n, q, busy, done, zero, q3,
                         mon_e.q, mon_e.busy, mon_e.done, (mon_e.q == 8'h00), mon_e.q3);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        step("rst0", 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        step("rst1", 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("idle_en", 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);

        // Basic countdown from 12.
        step("load12", 1'b0, 1'b1, 8'h12, 1'b1, 8'h12, 1'b1, 1'b0);
        for (int i = 11; i >= 1; i--) step("cnt12", 1'b0, 1'b0, 8'h00, 1'b1, bcd2(i), 1'b1, 1'b0);
`ifdef MOD10_DOWN_RELOAD_EN
        step("term12", 1'b0, 1'b0, 8'h00, 1'b1, 8'h12, 1'b1, 1'b1);
        step("after12", 1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 1'b0);
`else
        step("term12", 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1);
        step("after12", 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
`endif
        park();

        // Clamping of non-decimal digits.
        step("clampFA", 1'b0, 1'b1, 8'hFA, 1'b0, 8'h99, 1'b1, 1'b0);
        step("clamp3B", 1'b0, 1'b1, 8'h3B, 1'b0, 8'h39, 1'b1, 1'b0);
        park();

        // Three-digit borrow and clamp on the second instance.
        chk3_g = 1'b1;
        load3 = 1'b1; lv3 = 12'h100; eq3_g = 12'h100;
        step("d3load100", 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        load3 = 1'b0; eq3_g = 12'h099;
        step("d3borrow099", 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        eq3_g = 12'h098;
        step("d3dec098", 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        load3 = 1'b1; lv3 = 12'hF5A; eq3_g = 12'h959;
        step("d3clamp", 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        load3 = 1'b0; eq3_g = 12'h958;
        step("d3dec958", 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        load3 = 1'b1; lv3 = 12'h000; eq3_g = 12'h000;
        step("d3park", 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        load3 = 1'b0; chk3_g = 1'b0;

        // Stall behaviour and reload mid-run.
        step("load05", 1'b0, 1'b1, 8'h05, 1'b0, 8'h05, 1'b1, 1'b0);
        step("stall_e1", 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 1'b0);
        step("stall_e0", 1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 1'b0);
        step("stall_e1b", 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 1'b0);
        step("stall_e0b", 1'b0, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0);
        step("reload20", 1'b0, 1'b1, 8'h20, 1'b1, 8'h20, 1'b1, 1'b0);
        step("dec19", 1'b0, 1'b0, 8'h00, 1'b1, 8'h19, 1'b1, 1'b0);
        park();

        // Stall at 01, then load and reset colliding with the terminal step.
        step("load02", 1'b0, 1'b1, 8'h02, 1'b0, 8'h02, 1'b1, 1'b0);
        step("dec01", 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0);
        step("hold01", 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0);
        step("hold01b", 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0);
        step("load_vs_term", 1'b0, 1'b1, 8'h07, 1'b1, 8'h07, 1'b1, 1'b0);
        step("dec06", 1'b0, 1'b0, 8'h00, 1'b1, 8'h06, 1'b1, 1'b0);
        step("load01", 1'b0, 1'b1, 8'h01, 1'b0, 8'h01, 1'b1, 1'b0);
        step("reset_vs_term", 1'b1, 1'b1, 8'h07, 1'b1, 8'h00, 1'b0, 1'b0);
        step("post_reset", 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);

        // Periodic sequence from 03 (expectations depend on the build).
        step("load03", 1'b0, 1'b1, 8'h03, 1'b1, 8'h03, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) step("per03", 1'b0, 1'b0, 8'h00, 1'b1, per_q[k], per_b[k], per_d[k]);
        park();

        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
